// File: rtl/banco_registros_sb.sv
// Two-read/one-write register file with hardwired-zero x0, optional write-to-read bypass
// and a per-register busy scoreboard for RAW hazard detection at decode.
module banco_registros_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rsta,
    input  logic [AW-1:0]   read_reg1,
    input  logic [AW-1:0]   read_reg2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            busy1,
    output logic            busy2,
    input  logic            RegWrite,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    input  logic            mark_valid,
    input  logic [AW-1:0]   mark_reg,
    output logic            busy_any
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic wr_en;
    logic mark_en;
    logic fwd1;
    logic fwd2;

    assign wr_en   = RegWrite && (write_reg != '0);
    assign mark_en = mark_valid && (mark_reg != '0);

    always_ff @(posedge clk or negedge rsta) begin
        if (!rsta) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // Mark is applied after the clear so a same-register issue keeps the new producer busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[write_reg] = 1'b0;
        end
        if (mark_en) begin
            busy_d[mark_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rsta) begin
        if (!rsta) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign fwd1 = (BYPASS != 0) && wr_en && (write_reg == read_reg1);
    assign fwd2 = (BYPASS != 0) && wr_en && (write_reg == read_reg2);

    // Outputs are forced low during reset so the bypass path cannot leak write data.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        busy1      = 1'b0;
        busy2      = 1'b0;
        busy_any   = 1'b0;
        if (rsta) begin
            if (read_reg1 != '0) begin
                read_data1 = fwd1 ? write_data : regs_q[read_reg1];
            end
            if (read_reg2 != '0) begin
                read_data2 = fwd2 ? write_data : regs_q[read_reg2];
            end
            busy1    = busy_q[read_reg1] && !fwd1;
            busy2    = busy_q[read_reg2] && !fwd2;
            busy_any = |busy_q;
        end
    end

endmodule

// File: tb/tb_banco_registros_sb.sv
// Directed bench for banco_registros_sb: one instance with bypass, one without, sharing
// all inputs so the two forwarding behaviours can be compared in the same cycle.
module tb_banco_registros_sb;

    logic        clk;
    logic        rsta;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        mark_valid;
    logic [4:0]  mark_reg;

    logic [31:0] rd1_b;
    logic [31:0] rd2_b;
    logic        busy1_b;
    logic        busy2_b;
    logic        busy_any_b;
    logic [31:0] rd1_n;
    logic [31:0] rd2_n;
    logic        busy1_n;
    logic        busy2_n;
    logic        busy_any_n;

    int checks = 0;
    int errors = 0;

    banco_registros_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut (
        .clk        (clk),
        .rsta       (rsta),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (rd1_b),
        .read_data2 (rd2_b),
        .busy1      (busy1_b),
        .busy2      (busy2_b),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .mark_valid (mark_valid),
        .mark_reg   (mark_reg),
        .busy_any   (busy_any_b)
    );

    banco_registros_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_dut_nb (
        .clk        (clk),
        .rsta       (rsta),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (rd1_n),
        .read_data2 (rd2_n),
        .busy1      (busy1_n),
        .busy2      (busy2_n),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .mark_valid (mark_valid),
        .mark_reg   (mark_reg),
        .busy_any   (busy_any_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsta       = 1'b0;
        read_reg1  = '0;
        read_reg2  = '0;
        RegWrite   = 1'b0;
        write_reg  = '0;
        write_data = '0;
        mark_valid = 1'b0;
        mark_reg   = '0;
        #2;
        check("rst_busy_any", {31'd0, busy_any_b}, 32'd0);
        #10 rsta = 1'b1;

        // Every register reads zero after reset, both ports, both instances.
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            check("rst_rd1", rd1_b, 32'd0);
            check("rst_rd2", rd2_b, 32'd0);
            check("rst_busy", {29'd0, busy1_b, busy2_b, busy_any_b}, 32'd0);
            check("rst_rd1_nb", rd1_n, 32'd0);
        end

        tick();
        RegWrite = 1'b1; write_reg = 5'd1; write_data = 32'h0000_00FF;
        tick();
        write_reg = 5'd2; write_data = 32'h0000_00AA;
        tick();
        RegWrite = 1'b0;
        read_reg1 = 5'd1; read_reg2 = 5'd2;
        #1;
        check("wr_x1", rd1_b, 32'h0000_00FF);
        check("wr_x2", rd2_b, 32'h0000_00AA);
        check("wr_x1_nb", rd1_n, 32'h0000_00FF);

        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hDEAD_BEEF;
        read_reg1 = 5'd0;
        #1;
        check("x0_same_cycle", rd1_b, 32'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("x0_after", rd1_b, 32'd0);
        check("x0_after_nb", rd1_n, 32'd0);

        // Bypass versus storage-only in the write cycle.
        RegWrite = 1'b1; write_reg = 5'd5; write_data = 32'h1234_5678;
        read_reg1 = 5'd5;
        #1;
        check("byp_on", rd1_b, 32'h1234_5678);
        check("byp_off_before", rd1_n, 32'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("byp_off_after", rd1_n, 32'h1234_5678);
        check("byp_on_after", rd1_b, 32'h1234_5678);

        mark_valid = 1'b1; mark_reg = 5'd7;
        read_reg2 = 5'd7;
        #1;
        check("mark_not_yet", {31'd0, busy2_b}, 32'd0);
        tick();
        mark_valid = 1'b0;
        #1;
        check("mark_busy2", {31'd0, busy2_b}, 32'd1);
        check("mark_busy_any", {31'd0, busy_any_b}, 32'd1);
        check("mark_busy2_nb", {31'd0, busy2_n}, 32'd1);

        RegWrite = 1'b1; write_reg = 5'd7; write_data = 32'h0000_CAFE;
        #1;
        check("wb_busy2", {31'd0, busy2_b}, 32'd0);
        check("wb_rd2", rd2_b, 32'h0000_CAFE);
        check("wb_busy_any", {31'd0, busy_any_b}, 32'd1);
        check("wb_busy2_nb", {31'd0, busy2_n}, 32'd1);
        tick();
        RegWrite = 1'b0;
        #1;
        check("wb_after_any", {31'd0, busy_any_b}, 32'd0);
        check("wb_after_any_nb", {31'd0, busy_any_n}, 32'd0);
        check("wb_after_rd2_nb", rd2_n, 32'h0000_CAFE);

        // Same-register mark and write: mark wins, data still lands.
        mark_valid = 1'b1; mark_reg = 5'd9;
        tick();
        RegWrite = 1'b1; write_reg = 5'd9; write_data = 32'h0000_0099;
        tick();
        mark_valid = 1'b0; RegWrite = 1'b0;
        read_reg1 = 5'd9;
        #1;
        check("same_busy", {31'd0, busy1_b}, 32'd1);
        check("same_data", rd1_b, 32'h0000_0099);

        mark_valid = 1'b1; mark_reg = 5'd4;
        tick();
        mark_reg = 5'd3;
        RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'h0000_0044;
        tick();
        mark_valid = 1'b0; RegWrite = 1'b0;
        read_reg1 = 5'd3; read_reg2 = 5'd4;
        #1;
        check("diff_busy3", {31'd0, busy1_b}, 32'd1);
        check("diff_busy4", {31'd0, busy2_b}, 32'd0);
        check("diff_data4", rd2_b, 32'h0000_0044);

        mark_valid = 1'b1; mark_reg = 5'd10;
        tick();
        mark_reg = 5'd11;
        tick();
        mark_valid = 1'b0;
        read_reg1 = 5'd10; read_reg2 = 5'd9;
        #1;
        check("pre_rst_busy10", {31'd0, busy1_b}, 32'd1);
        #1 rsta = 1'b0;
        #1;
        check("mid_rst_any", {31'd0, busy_any_b}, 32'd0);
        check("mid_rst_busy1", {31'd0, busy1_b}, 32'd0);
        check("mid_rst_rd2", rd2_b, 32'd0);
        RegWrite = 1'b1; write_reg = 5'd9; write_data = 32'h0000_0005;
        #1;
        check("mid_rst_byp", rd2_b, 32'd0);
        RegWrite = 1'b0;
        @(negedge clk);
        rsta = 1'b1;
        @(posedge clk);
        #1;
        RegWrite = 1'b1; write_reg = 5'd10; write_data = 32'h0000_0001;
        tick();
        RegWrite = 1'b0;
        #1;
        check("post_rst_rd1", rd1_b, 32'h0000_0001);
        check("post_rst_busy1", {31'd0, busy1_b}, 32'd0);
        check("post_rst_any", {31'd0, busy_any_b}, 32'd0);
        check("post_rst_x9", rd2_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
